// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder.
// Operands are captured on a valid/ready input handshake, added LSB-first one
// bit per clock through a full adder made of two half_adder cells and an OR
// gate, and the registered {carry, sum} is held on a valid/ready output
// handshake until the consumer takes it.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // The counter only needs to reach WIDTH-1; a 1-bit counter covers WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_next;
    logic             c;
    logic [CW-1:0]    cnt;

    logic s1;
    logic c1;
    logic s2;
    logic c2;
    logic c_next;

    logic load;
    logic step;

    // One-bit full adder: first cell adds the operand bits, second folds in
    // the registered carry; either cell producing a carry makes the carry-out.
    half_adder u_ha_ab (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha_c (
        .x (s1),
        .y (c),
        .s (s2),
        .c (c2)
    );

    assign c_next = c1 | c2;

    // New sum bit enters at the MSB so that after WIDTH shifts the first
    // (LSB) bit computed has arrived at bit 0.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_sr_next = s2;
        end else begin : g_sum_wn
            assign sum_sr_next = {s2, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register; reset abandons any addition in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; the shift phase ends on the edge
    // that processes bit WIDTH-1.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load operands on acceptance, then shift one bit per clock.
    // sum_sr is left alone on load so the last result stays visible until
    // the first shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_sr_next;
            c      <= c_next;
            cnt    <= cnt + CW'(1);
        end
    end

    assign sum   = sum_sr;
    assign carry = c;

endmodule

// half_adder: single-bit sum and carry of two inputs.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).

module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         carry;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;

    logic         in_valid1;
    logic         in_ready1;
    logic         out_valid1;
    logic         out_ready1;
    logic         carry1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic [0:0]   sum1;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry     (carry1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
        int         hold;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic sum;
        logic carry;
    } vec1_t;

    vec_t  vecs[8];
    vec1_t vecs1[3];

    // Compare one observed value against the bench's expectation.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one complete WIDTH=8 operation, holding out_ready low for 'hold'
    // cycles once the result appears.
    task automatic apply_stimulus(input logic [7:0] va, input logic [7:0] vb,
                                  input logic [7:0] es, input logic ec,
                                  input int hold, input string tag);
        int lat;
        int busy;
        @(negedge clk);
        check_output({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 0;
        busy     = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        if (!in_ready) busy++;
        check_output({tag, " latency"}, 32'(lat), 32'(W));
        check_output({tag, " sum"}, 32'(sum), 32'(es));
        check_output({tag, " carry"}, 32'(carry), 32'(ec));
        if (hold == 0) begin
            check_output({tag, " in_ready_low_cycles"}, 32'(busy), 32'(W + 1));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output({tag, " held_valid"}, 32'(out_valid), 32'd1);
            check_output({tag, " held_sum"}, 32'({carry, sum}), 32'({ec, es}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_output({tag, " valid_drop"}, 32'(out_valid), 32'd0);
        check_output({tag, " back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] exp9;
        int         sent;
        int         got;
        int         cyc;
        int         lat;
        logic       accept_next;
        logic       stale;

        vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0, 0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 2};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1, 1};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 0};
        vecs[6] = '{8'h0F, 8'h01, 8'h10, 1'b0, 3};
        vecs[7] = '{8'hC3, 8'h3C, 8'hFF, 1'b0, 0};

        vecs1[0] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs1[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs1[2] = '{1'b0, 1'b0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        a1         = '0;
        b1         = '0;

        #1;
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset sum", 32'(sum), 32'd0);
        check_output("reset carry", 32'(carry), 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        check_output("reset w1 in_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, including full ripple and held results.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry,
                           vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid asserted throughout the held result.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'h12;
        b         = 8'h34;
        @(posedge clk);
        @(negedge clk);
        a   = 8'hAA;
        b   = 8'h11;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_output("bp latency", 32'(lat), 32'(W));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp held_result", 32'({carry, sum}), 32'h046);
            check_output("bp held_valid", 32'(out_valid), 32'd1);
            check_output("bp in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_output("bp idle_after", 32'(in_ready), 32'd1);
        check_output("bp valid_drop", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_output("bp second_latency", 32'(lat), 32'(W));
        check_output("bp second_result", 32'({carry, sum}), 32'h0BB);
        @(negedge clk);

        // Reset during the third shift cycle.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h0F;
        b         = 8'h01;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst out_valid", 32'(out_valid), 32'd0);
        check_output("midrst sum", 32'(sum), 32'd0);
        check_output("midrst carry", 32'(carry), 32'd0);
        check_output("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check_output("midrst no_stale_valid", 32'(stale), 32'd0);
        apply_stimulus(8'h03, 8'h04, 8'h07, 1'b0, 0, "post_reset");

        // WIDTH=1 instance: a single full-adder evaluation.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("w1_%0d in_ready", i), 32'(in_ready1), 32'd1);
            in_valid1 = 1'b1;
            a1        = vecs1[i].a;
            b1        = vecs1[i].b;
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            check_output($sformatf("w1_%0d shift_valid", i), 32'(out_valid1), 32'd0);
            @(negedge clk);
            check_output($sformatf("w1_%0d done_valid", i), 32'(out_valid1), 32'd1);
            check_output($sformatf("w1_%0d result", i), 32'({carry1, sum1}),
                         32'({vecs1[i].carry, vecs1[i].sum}));
            @(negedge clk);
            check_output($sformatf("w1_%0d valid_drop", i), 32'(out_valid1), 32'd0);
        end

        // Randomised traffic with gaps on both handshakes against a+b.
        sent        = 0;
        got         = 0;
        cyc         = 0;
        accept_next = 1'b0;
        in_valid    = 1'b0;
        while ((sent < 20 || got < 20) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (accept_next) begin
                in_valid    = 1'b0;
                accept_next = 1'b0;
            end
            if (!in_valid && sent < 20 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                a        = 8'($urandom);
                b        = 8'($urandom);
            end
            if (in_valid && in_ready) begin
                exp9 = {1'b0, a} + {1'b0, b};
                q.push_back(exp9);
                sent++;
                accept_next = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                got++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand unexpected_result: got 0x%0h expected none", {carry, sum});
                end else begin
                    exp9 = q.pop_front();
                    check_output($sformatf("rand result%0d", got), 32'({carry, sum}), 32'(exp9));
                end
            end
        end
        in_valid = 1'b0;
        check_output("rand completed_in_budget", 32'(cyc < 4000), 32'd1);
        check_output("rand results_count", 32'(got), 32'd20);
        check_output("rand leftover", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
